riscv_cpu_decode_unit: RTL and testbench
========================================

Name: riscv_cpu_decode_unit

Overview:
Second pipeline stage of the RISC-V (RV32I) core, directly downstream of the fetch unit. It consumes the fetch stage's instruction/PC pair and decodes it into register addresses, a sign-extended immediate, an operation class and control bits. These are held in a one-deep pipeline register feeding execute. It detects load-use hazards, inserts a bubble and back-pressures fetch. It squashes its contents on a branch flush.

Parameters:
RESET_VECTOR, 32'h00000000, value of ex_pcaddr after reset.

Ports:
cpu_clk  in  1  core clock; all state on rising edge
cpu_reset  in  1  synchronous, active-high reset
dec_instr  in  32  instruction from fetch (pipe_instr)
dec_pcaddr  in  32  PC of dec_instr (pipe_pcaddr)
dec_stall_in  in  1  execute cannot accept; hold stage
dec_flush  in  1  taken branch/jump resolved; squash stage
dec_stall_out  out  1  to fetch_stall_in; freeze fetch
ex_valid  out  1  ex_* fields carry a real instruction
ex_pcaddr  out  32  PC of decoded instruction
ex_opclass  out  4  riscv_opclass_t enum
ex_rd / ex_rs1 / ex_rs2  out  5 each  register indices
ex_imm  out  32  sign-extended immediate
ex_funct3  out  3  instr[14:12]
ex_funct7b5  out  1  instr[30]
ex_rd_we  out  1  destination write enable
ex_illegal  out  1  undecodable instruction

Behaviour:
- Latency 1 cycle: dec_instr sampled at edge N appears on ex_* after edge N.
- Reset (cpu_reset=1 at an edge):
  - ex_valid=0; ex_pcaddr=RESET_VECTOR; all other ex_* = 0.
  - dec_stall_out=0.
  - Reset mid-stall or mid-hazard discards everything.
- Opclass from instr[6:0]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM. Anything else is ILLEGAL.
- Illegal conditions:
  - instr[1:0]!=2'b11.
  - OP with funct7 not in {0x00,0x20}.
  - OP with funct7=0x20 and funct3 not in {000,101}.
  - OPIMM shifts (funct3 001/101) with instr[31:25] not in {0x00,0x20}, or 0x20 with funct3=001.
  - When illegal: ex_illegal=1, ex_rd_we=0, ex_valid=1.
- Immediates (all 32-bit, sign bit instr[31]):
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - OP/FENCE/SYSTEM: imm=I-form. Illegal: imm=0.
- ex_rd_we=1 only for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP with rd!=0.
- The fetch NOP (0x00000033) decodes as OP, rd=0, so rd_we=0. It is a valid no-effect instruction.
- Register use:
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OPIMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
  - Unused rs fields are output as 0.
- Load-use hazard (combinational), true when all hold:
  - ex_valid, ex_opclass=LOAD, ex_rd!=0;
  - (uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd).
- Priority per edge: reset > flush > dec_stall_in > hazard > normal.
  - flush: ex_valid<=0, other fields don't-care. dec_stall_out=0 this cycle even if dec_stall_in or hazard is set.
  - dec_stall_in (no flush): all ex_* held; dec_stall_out=1.
  - hazard: ex_valid<=0 (bubble, ex_rd_we<=0); dec_stall_out=1. Fetch holds dec_instr, which is decoded next cycle. The hazard clears automatically after exactly one bubble.
  - normal: ex_* <= decode(dec_instr); dec_stall_out=0.
- dec_stall_out = ~flush & (dec_stall_in | hazard). No registered stall state.

Decomposition:
- Shared package riscv_cpu_pkg:
  - riscv_opclass_t enum (4-bit);
  - opcode constants (OPC_LUI=7'b0110111, OPC_JAL=7'b1101111, ...);
  - RISCV_INSTR_NOP;
  - funct7 constants.
- One sub-module, riscv_cpu_imm_gen: combinational, instr + opclass -> 32-bit immediate.

Test Plan:
1. Reset 2 cycles, then dec_instr=0x00500093 (addi x1,x0,5) -> next cycle ex_valid=1, opclass=OPIMM, rd=1, rs1=0, imm=0x00000005, rd_we=1, dec_stall_out=0.
2. 0x0000A103 (lw x2,0(x1)) then 0x002081B3 (add x3,x1,x2) held by fetch -> dec_stall_out=1 one cycle, bubble ex_valid=0, next cycle add issued with rd=3, rs1=1, rs2=2.
3. 0xFE000EE3 (beq x0,x0,-4) -> opclass=BRANCH, imm=0xFFFFFFFC, rd_we=0. 0x0040006F (jal x0,4) -> imm=0x00000004, rd_we=0.
4. Load-use hazard present with dec_flush=1 same cycle -> dec_stall_out=0, ex_valid=0 next cycle. Same with dec_stall_in=1 -> flush still wins.
5. dec_stall_in=1 for 3 cycles while dec_instr changes -> ex_* unchanged, dec_stall_out=1. Release -> new instruction appears next cycle.
6. dec_instr=0xFFFFFFFF -> ex_illegal=1, rd_we=0. Then cpu_reset=1 mid-stall -> all ex_* at reset values, ex_pcaddr=RESET_VECTOR, next cycle.

Source files
------------

// File: rtl/riscv_cpu_pkg.sv
// Shared RV32I core definitions: operation classes, major opcodes, funct7 values and the
// execute-stage pipeline register layout.
package riscv_cpu_pkg;

   typedef enum logic [3:0] {
      OpIllegal = 4'd0,
      OpLui     = 4'd1,
      OpAuipc   = 4'd2,
      OpJal     = 4'd3,
      OpJalr    = 4'd4,
      OpBranch  = 4'd5,
      OpLoad    = 4'd6,
      OpStore   = 4'd7,
      OpOpImm   = 4'd8,
      OpOp      = 4'd9,
      OpFence   = 4'd10,
      OpSystem  = 4'd11
   } riscv_opclass_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] RISCV_INSTR_NOP = 32'h0000_0033;

   localparam logic [6:0] FUNCT7_BASE = 7'h00;
   localparam logic [6:0] FUNCT7_ALT  = 7'h20;

   typedef struct packed {
      logic           valid;
      logic [31:0]    pcaddr;
      riscv_opclass_t opclass;
      logic [4:0]     rd;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic [31:0]    imm;
      logic [2:0]     funct3;
      logic           funct7b5;
      logic           rd_we;
      logic           illegal;
   } riscv_ex_t;

   // Major-opcode lookup only; funct-level legality is checked by the decoder.
   function automatic riscv_opclass_t opclass_of(logic [6:0] opcode);
      riscv_opclass_t cls;
      case (opcode)
         OPC_LUI:    cls = OpLui;
         OPC_AUIPC:  cls = OpAuipc;
         OPC_JAL:    cls = OpJal;
         OPC_JALR:   cls = OpJalr;
         OPC_BRANCH: cls = OpBranch;
         OPC_LOAD:   cls = OpLoad;
         OPC_STORE:  cls = OpStore;
         OPC_OPIMM:  cls = OpOpImm;
         OPC_OP:     cls = OpOp;
         OPC_FENCE:  cls = OpFence;
         OPC_SYSTEM: cls = OpSystem;
         default:    cls = OpIllegal;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/riscv_cpu_imm_gen.sv
// Immediate generator: selects the RV32I immediate format from the operation class and
// sign-extends it from instr[31].
module riscv_cpu_imm_gen
   import riscv_cpu_pkg::*;
(
   input  logic [31:0]    instr,
   input  riscv_opclass_t opclass,
   output logic [31:0]    imm
);

   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic        unused_opcode;

   assign unused_opcode = ^instr[6:0];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      imm = '0;
      case (opclass)
         OpLui, OpAuipc:                                 imm = imm_u;
         OpJal:                                          imm = imm_j;
         OpBranch:                                       imm = imm_b;
         OpStore:                                        imm = imm_s;
         OpJalr, OpLoad, OpOpImm, OpOp, OpFence, OpSystem: imm = imm_i;
         default:                                        imm = '0;
      endcase
   end

endmodule

// File: rtl/riscv_cpu_decode_unit.sv
// Decode stage: turns the fetched instruction into execute-stage control fields held in a
// one-deep pipeline register, with load-use bubble insertion and branch-flush squash.
module riscv_cpu_decode_unit
   import riscv_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic           cpu_clk,
   input  logic           cpu_reset,
   input  logic [31:0]    dec_instr,
   input  logic [31:0]    dec_pcaddr,
   input  logic           dec_stall_in,
   input  logic           dec_flush,
   output logic           dec_stall_out,
   output logic           ex_valid,
   output logic [31:0]    ex_pcaddr,
   output riscv_opclass_t ex_opclass,
   output logic [4:0]     ex_rd,
   output logic [4:0]     ex_rs1,
   output logic [4:0]     ex_rs2,
   output logic [31:0]    ex_imm,
   output logic [2:0]     ex_funct3,
   output logic           ex_funct7b5,
   output logic           ex_rd_we,
   output logic           ex_illegal
);

   riscv_ex_t      ex_q;
   riscv_ex_t      ex_d;
   riscv_ex_t      dec_fields;

   riscv_opclass_t base_class;
   riscv_opclass_t dec_class;
   logic           dec_illegal;
   logic           uses_rs1;
   logic           uses_rs2;
   logic [4:0]     dec_rd;
   logic [4:0]     dec_rs1;
   logic [4:0]     dec_rs2;
   logic [31:0]    dec_imm;
   logic           dec_rd_we;
   logic           hazard;

   logic [2:0]     funct3;
   logic [6:0]     funct7;

   assign funct3 = dec_instr[14:12];
   assign funct7 = dec_instr[31:25];

   always_comb begin
      base_class  = opclass_of(dec_instr[6:0]);
      dec_illegal = (base_class == OpIllegal);
      if (base_class == OpOp) begin
         if ((funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT)) begin
            dec_illegal = 1'b1;
         end
         // Only SUB and SRA use the alternate funct7.
         if ((funct7 == FUNCT7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
            dec_illegal = 1'b1;
         end
      end
      if (base_class == OpOpImm) begin
         if ((funct3 == 3'b001) && (funct7 != FUNCT7_BASE)) begin
            dec_illegal = 1'b1;
         end
         if ((funct3 == 3'b101) && (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT)) begin
            dec_illegal = 1'b1;
         end
      end
   end

   assign dec_class = dec_illegal ? OpIllegal : base_class;

   assign uses_rs1 = dec_class inside {OpJalr, OpBranch, OpLoad, OpStore, OpOpImm, OpOp};
   assign uses_rs2 = dec_class inside {OpBranch, OpStore, OpOp};

   assign dec_rd  = dec_illegal ? 5'd0 : dec_instr[11:7];
   assign dec_rs1 = uses_rs1 ? dec_instr[19:15] : 5'd0;
   assign dec_rs2 = uses_rs2 ? dec_instr[24:20] : 5'd0;

   assign dec_rd_we = (dec_class inside {OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpOpImm, OpOp})
                      && (dec_rd != 5'd0);

   riscv_cpu_imm_gen u_imm_gen (
      .instr   (dec_instr),
      .opclass (dec_class),
      .imm     (dec_imm)
   );

   always_comb begin
      dec_fields.valid    = 1'b1;
      dec_fields.pcaddr   = dec_pcaddr;
      dec_fields.opclass  = dec_class;
      dec_fields.rd       = dec_rd;
      dec_fields.rs1      = dec_rs1;
      dec_fields.rs2      = dec_rs2;
      dec_fields.imm      = dec_imm;
      dec_fields.funct3   = funct3;
      dec_fields.funct7b5 = dec_instr[30];
      dec_fields.rd_we    = dec_rd_we;
      dec_fields.illegal  = dec_illegal;
   end

   // A load in execute cannot forward to the instruction now in decode.
   assign hazard = ex_q.valid && (ex_q.opclass == OpLoad) && (ex_q.rd != 5'd0)
                   && ((uses_rs1 && (dec_rs1 == ex_q.rd)) || (uses_rs2 && (dec_rs2 == ex_q.rd)));

   assign dec_stall_out = ~dec_flush & (dec_stall_in | hazard);

   always_comb begin
      ex_d = ex_q;
      if (dec_flush) begin
         ex_d.valid = 1'b0;
         ex_d.rd_we = 1'b0;
      end else if (dec_stall_in) begin
         ex_d = ex_q;
      end else if (hazard) begin
         ex_d.valid = 1'b0;
         ex_d.rd_we = 1'b0;
      end else begin
         ex_d = dec_fields;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_reset) begin
         ex_q <= '{valid: 1'b0, pcaddr: RESET_VECTOR, opclass: OpIllegal, rd: 5'd0, rs1: 5'd0,
                   rs2: 5'd0, imm: 32'd0, funct3: 3'd0, funct7b5: 1'b0, rd_we: 1'b0,
                   illegal: 1'b0};
      end else begin
         ex_q <= ex_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_pcaddr   = ex_q.pcaddr;
   assign ex_opclass  = ex_q.opclass;
   assign ex_rd       = ex_q.rd;
   assign ex_rs1      = ex_q.rs1;
   assign ex_rs2      = ex_q.rs2;
   assign ex_imm      = ex_q.imm;
   assign ex_funct3   = ex_q.funct3;
   assign ex_funct7b5 = ex_q.funct7b5;
   assign ex_rd_we    = ex_q.rd_we;
   assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_riscv_cpu_decode_unit.sv
// Self-checking bench for the decode stage: an instruction-level reference model compared
// against the DUT every cycle, plus directed literal checks.
module tb_riscv_cpu_decode_unit;
   import riscv_cpu_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0080;

   logic           cpu_clk = 1'b0;
   logic           cpu_reset;
   logic [31:0]    dec_instr;
   logic [31:0]    dec_pcaddr;
   logic           dec_stall_in;
   logic           dec_flush;
   logic           dec_stall_out;
   logic           ex_valid;
   logic [31:0]    ex_pcaddr;
   riscv_opclass_t ex_opclass;
   logic [4:0]     ex_rd;
   logic [4:0]     ex_rs1;
   logic [4:0]     ex_rs2;
   logic [31:0]    ex_imm;
   logic [2:0]     ex_funct3;
   logic           ex_funct7b5;
   logic           ex_rd_we;
   logic           ex_illegal;

   always #5 cpu_clk = ~cpu_clk;

   riscv_cpu_decode_unit #(.RESET_VECTOR(RV)) dut (
      .cpu_clk       (cpu_clk),
      .cpu_reset     (cpu_reset),
      .dec_instr     (dec_instr),
      .dec_pcaddr    (dec_pcaddr),
      .dec_stall_in  (dec_stall_in),
      .dec_flush     (dec_flush),
      .dec_stall_out (dec_stall_out),
      .ex_valid      (ex_valid),
      .ex_pcaddr     (ex_pcaddr),
      .ex_opclass    (ex_opclass),
      .ex_rd         (ex_rd),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_imm        (ex_imm),
      .ex_funct3     (ex_funct3),
      .ex_funct7b5   (ex_funct7b5),
      .ex_rd_we      (ex_rd_we),
      .ex_illegal    (ex_illegal)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      riscv_opclass_t op;
      logic [4:0]     rd;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic [31:0]    imm;
      logic [2:0]     f3;
      logic           f7b5;
      logic           we;
      logic           ill;
   } exp_t;

   logic        m_valid;
   logic [31:0] m_pc;
   exp_t        m_ex;
   bit          m_known;
   bit          m_we_chk;
   bit          chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t m_decode(input logic [31:0] i);
      exp_t       e;
      logic [6:0] f7;
      logic [2:0] f3;
      bit         ill;
      bit         u1;
      bit         u2;
      bit         wr;
      e   = '0;
      f7  = i[31:25];
      f3  = i[14:12];
      ill = 1'b0;
      u1  = 1'b0;
      u2  = 1'b0;
      wr  = 1'b0;
      case (i[6:0])
         7'h37: begin e.op = OpLui;   wr = 1; e.imm = {i[31:12], 12'h000}; end
         7'h17: begin e.op = OpAuipc; wr = 1; e.imm = {i[31:12], 12'h000}; end
         7'h6f: begin
            e.op = OpJal; wr = 1;
            e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         end
         7'h67: begin e.op = OpJalr; u1 = 1; wr = 1; e.imm = 32'($signed(i[31:20])); end
         7'h63: begin
            e.op = OpBranch; u1 = 1; u2 = 1;
            e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         end
         7'h03: begin e.op = OpLoad; u1 = 1; wr = 1; e.imm = 32'($signed(i[31:20])); end
         7'h23: begin
            e.op = OpStore; u1 = 1; u2 = 1; e.imm = 32'($signed({i[31:25], i[11:7]}));
         end
         7'h13: begin
            e.op = OpOpImm; u1 = 1; wr = 1; e.imm = 32'($signed(i[31:20]));
            if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
            if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1;
         end
         7'h33: begin
            e.op = OpOp; u1 = 1; u2 = 1; wr = 1; e.imm = 32'($signed(i[31:20]));
            if (f7 != 7'h00 && f7 != 7'h20) ill = 1;
            if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill = 1;
         end
         7'h0f: begin e.op = OpFence;  e.imm = 32'($signed(i[31:20])); end
         7'h73: begin e.op = OpSystem; e.imm = 32'($signed(i[31:20])); end
         default: ill = 1;
      endcase
      e.f3   = f3;
      e.f7b5 = i[30];
      if (ill) begin
         e.op  = OpIllegal;
         e.imm = '0;
         e.ill = 1'b1;
         return e;
      end
      e.rd  = i[11:7];
      e.rs1 = u1 ? i[19:15] : 5'd0;
      e.rs2 = u2 ? i[24:20] : 5'd0;
      e.we  = wr && (e.rd != 5'd0);
      return e;
   endfunction

   function automatic bit m_hazard(input logic [31:0] i);
      exp_t e;
      e = m_decode(i);
      return m_valid && (m_ex.op == OpLoad) && (m_ex.rd != 5'd0)
             && ((e.rs1 == m_ex.rd) || (e.rs2 == m_ex.rd));
   endfunction

   task automatic m_update();
      bit haz;
      haz = m_hazard(dec_instr);
      if (cpu_reset) begin
         m_valid = 0; m_pc = RV; m_ex = '0; m_known = 1; m_we_chk = 1;
      end else if (dec_flush) begin
         m_valid = 0; m_known = 0; m_we_chk = 0;
      end else if (dec_stall_in) begin
         m_valid = m_valid;
      end else if (haz) begin
         m_valid = 0; m_ex.we = 0; m_known = 0; m_we_chk = 1;
      end else begin
         m_valid = 1; m_pc = dec_pcaddr; m_ex = m_decode(dec_instr); m_known = 1; m_we_chk = 1;
      end
   endtask

   always @(negedge cpu_clk) begin
      if (chk_en) begin
         if (!cpu_reset) begin
            chk("stall_out", 32'(dec_stall_out),
                32'(!dec_flush && (dec_stall_in || m_hazard(dec_instr))));
         end
         chk("valid", 32'(ex_valid), 32'(m_valid));
         if (m_we_chk) chk("rd_we", 32'(ex_rd_we), 32'(m_ex.we));
         if (m_known) begin
            chk("pcaddr", ex_pcaddr, m_pc);
            chk("opclass", 32'(ex_opclass), 32'(m_ex.op));
            chk("rd", 32'(ex_rd), 32'(m_ex.rd));
            chk("rs1", 32'(ex_rs1), 32'(m_ex.rs1));
            chk("rs2", 32'(ex_rs2), 32'(m_ex.rs2));
            chk("imm", ex_imm, m_ex.imm);
            chk("funct3", 32'(ex_funct3), 32'(m_ex.f3));
            chk("funct7b5", 32'(ex_funct7b5), 32'(m_ex.f7b5));
            chk("illegal", 32'(ex_illegal), 32'(m_ex.ill));
         end
      end
   end

   task automatic drive(input logic [31:0] i, input logic [31:0] pc, input logic st,
                        input logic fl, input logic rs);
      dec_instr = i; dec_pcaddr = pc; dec_stall_in = st; dec_flush = fl; cpu_reset = rs;
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
      m_update();
   endtask

   // Fetch keeps presenting the instruction while decode back-pressures it.
   task automatic issue(input logic [31:0] i, input logic [31:0] pc);
      bit h;
      drive(i, pc, 1'b0, 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) begin
         h = m_hazard(i);
         tick();
         if (!h) break;
      end
   endtask

   localparam int NV = 20;
   logic [31:0] vec [NV] = '{
      32'h123452B7, 32'h00001517, 32'h000080E7, 32'hFE112E23, 32'h402081B3,
      32'h020081B3, 32'h402091B3, 32'h4020D093, 32'h40209093, 32'h00000001,
      32'h0000000F, 32'h00000073, 32'h00000033, 32'h0000A283, 32'h00128313,
      32'h0000A003, 32'h000001B3, 32'h0000A383, 32'h0070A023, 32'hFFF00093
   };

   initial begin
      drive(RISCV_INSTR_NOP, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_valid", 32'(ex_valid), 32'h0);
      chk("rst_pcaddr", ex_pcaddr, RV);
      chk("rst_imm", ex_imm, 32'h0);

      // addi x1,x0,5
      issue(32'h00500093, 32'h100);
      chk("addi_valid", 32'(ex_valid), 32'h1);
      chk("addi_op", 32'(ex_opclass), 32'(OpOpImm));
      chk("addi_rd", 32'(ex_rd), 32'd1);
      chk("addi_imm", ex_imm, 32'h5);
      chk("addi_we", 32'(ex_rd_we), 32'h1);

      // lw x2,0(x1) followed by dependent add x3,x1,x2
      issue(32'h0000A103, 32'h104);
      drive(32'h002081B3, 32'h108, 1'b0, 1'b0, 1'b0);
      #1 chk("lu_stall", 32'(dec_stall_out), 32'h1);
      tick();
      chk("lu_bubble", 32'(ex_valid), 32'h0);
      #1 chk("lu_release", 32'(dec_stall_out), 32'h0);
      tick();
      chk("add_valid", 32'(ex_valid), 32'h1);
      chk("add_rd", 32'(ex_rd), 32'd3);
      chk("add_rs1", 32'(ex_rs1), 32'd1);
      chk("add_rs2", 32'(ex_rs2), 32'd2);

      issue(32'hFE000EE3, 32'h10C);
      chk("beq_op", 32'(ex_opclass), 32'(OpBranch));
      chk("beq_imm", ex_imm, 32'hFFFFFFFC);
      chk("beq_we", 32'(ex_rd_we), 32'h0);
      issue(32'h0040006F, 32'h110);
      chk("jal_imm", ex_imm, 32'h00000004);
      chk("jal_we", 32'(ex_rd_we), 32'h0);

      // Flush beats a pending load-use hazard, and beats stall_in too
      issue(32'h0000A103, 32'h140);
      drive(32'h002081B3, 32'h144, 1'b0, 1'b1, 1'b0);
      #1 chk("fl_haz_stall", 32'(dec_stall_out), 32'h0);
      tick();
      chk("fl_haz_valid", 32'(ex_valid), 32'h0);
      issue(32'h0000A103, 32'h148);
      drive(32'h002081B3, 32'h14C, 1'b1, 1'b1, 1'b0);
      #1 chk("fl_st_stall", 32'(dec_stall_out), 32'h0);
      tick();
      chk("fl_st_valid", 32'(ex_valid), 32'h0);

      // Downstream stall holds the stage for three cycles
      issue(32'h00500093, 32'h200);
      for (int k = 0; k < 3; k++) begin
         drive(32'h00A00113 + 32'(k << 7), 32'h300 + 32'(4 * k), 1'b1, 1'b0, 1'b0);
         #1 chk("st_stall", 32'(dec_stall_out), 32'h1);
         tick();
         chk("st_hold_pc", ex_pcaddr, 32'h200);
      end
      issue(32'h123452B7, 32'h310);
      chk("rel_pc", ex_pcaddr, 32'h310);
      chk("rel_op", 32'(ex_opclass), 32'(OpLui));
      chk("rel_imm", ex_imm, 32'h12345000);

      for (int v = 0; v < NV; v++) issue(vec[v], 32'h400 + 32'(4 * v));

      issue(32'hFFFFFFFF, 32'h500);
      chk("ill_flag", 32'(ex_illegal), 32'h1);
      chk("ill_valid", 32'(ex_valid), 32'h1);
      chk("ill_we", 32'(ex_rd_we), 32'h0);
      drive(RISCV_INSTR_NOP, 32'h504, 1'b1, 1'b0, 1'b0);
      tick();
      drive(RISCV_INSTR_NOP, 32'h504, 1'b1, 1'b0, 1'b1);
      tick();
      chk("mid_rst_valid", 32'(ex_valid), 32'h0);
      chk("mid_rst_pc", ex_pcaddr, RV);
      chk("mid_rst_ill", 32'(ex_illegal), 32'h0);
      chk("mid_rst_op", 32'(ex_opclass), 32'(OpIllegal));
      drive(RISCV_INSTR_NOP, 32'h508, 1'b0, 1'b0, 1'b0);
      #1 chk("post_rst_stall", 32'(dec_stall_out), 32'h0);
      tick();
      tick();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
